// File: rtl/axi_arbiter.sv
// axi_arbiter
//   Shares one downstream AXI master port (io_*) between two requesters:
//   the instruction fetch unit (IFU, reads only) and the load/store unit
//   (LSU, reads and single-beat writes). One transaction is granted at a
//   time. Arbitration happens in IDLE and takes one cycle. A grant is held
//   until its completion handshake, with no preemption. IFU-vs-LSU
//   conflicts are resolved round-robin.
//
//   Ports
//     clock, reset            : rising-edge clock, asynchronous active-low reset
//     ifu_ar*/ifu_r*          : IFU read address / read data (slave side)
//     lsu_ar*/lsu_r*          : LSU read address / read data (slave side)
//     lsu_aw*/lsu_w*/lsu_b*   : LSU write address / data / response (slave side)
//     io_ar*/io_r*            : downstream read channels (master side)
//     io_aw*/io_w*/io_b*      : downstream write channels (master side);
//                               io_awlen tied 0, io_wlast tied 1
module axi_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   // IFU read
   input  logic                ifu_arvalid,
   input  logic [ADDR_W-1:0]   ifu_araddr,
   input  logic [7:0]          ifu_arlen,
   output logic                ifu_arready,
   output logic                ifu_rvalid,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic [1:0]          ifu_rresp,
   output logic                ifu_rlast,
   input  logic                ifu_rready,
   // LSU read
   input  logic                lsu_arvalid,
   input  logic [ADDR_W-1:0]   lsu_araddr,
   input  logic [7:0]          lsu_arlen,
   output logic                lsu_arready,
   output logic                lsu_rvalid,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic [1:0]          lsu_rresp,
   output logic                lsu_rlast,
   input  logic                lsu_rready,
   // LSU write
   input  logic                lsu_awvalid,
   input  logic [ADDR_W-1:0]   lsu_awaddr,
   output logic                lsu_awready,
   input  logic                lsu_wvalid,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   output logic                lsu_wready,
   output logic                lsu_bvalid,
   output logic [1:0]          lsu_bresp,
   input  logic                lsu_bready,
   // Downstream master
   output logic                io_arvalid,
   output logic [ADDR_W-1:0]   io_araddr,
   output logic [7:0]          io_arlen,
   input  logic                io_arready,
   input  logic                io_rvalid,
   input  logic [DATA_W-1:0]   io_rdata,
   input  logic [1:0]          io_rresp,
   input  logic                io_rlast,
   output logic                io_rready,
   output logic                io_awvalid,
   output logic [ADDR_W-1:0]   io_awaddr,
   output logic [7:0]          io_awlen,
   input  logic                io_awready,
   output logic                io_wvalid,
   output logic [DATA_W-1:0]   io_wdata,
   output logic [DATA_W/8-1:0] io_wstrb,
   output logic                io_wlast,
   input  logic                io_wready,
   input  logic                io_bvalid,
   input  logic [1:0]          io_bresp,
   output logic                io_bready
);

   typedef enum logic [1:0] {IDLE, RD_IFU, RD_LSU, WR_LSU} state_e;

   state_e state_q, state_d;
   logic   last_lsu_q, last_lsu_d;   // 1: LSU held the most recent grant
   logic   addr_done_q, addr_done_d; // AR/AW already accepted in this grant
   logic   w_done_q, w_done_d;       // W beat already accepted in this grant

   logic ifu_req, lsu_req;
   logic ar_hs, aw_hs, w_hs, rd_done, wr_done;

   assign ifu_req = ifu_arvalid;
   assign lsu_req = lsu_awvalid | lsu_arvalid;
   assign ar_hs   = io_arvalid & io_arready;
   assign aw_hs   = io_awvalid & io_awready;
   assign w_hs    = io_wvalid & io_wready;
   // io_rready / io_bready are forced 0 outside the matching states, so
   // stray responses in IDLE or the other direction never end a grant.
   assign rd_done = io_rvalid & io_rready & io_rlast;
   assign wr_done = io_bvalid & io_bready;

   // Payloads are passed through unconditionally; only valid/ready are gated.
   assign io_araddr = (state_q == RD_LSU) ? lsu_araddr : ifu_araddr;
   assign io_arlen  = (state_q == RD_LSU) ? lsu_arlen  : ifu_arlen;
   assign io_awaddr = lsu_awaddr;
   assign io_awlen  = 8'd0;
   assign io_wdata  = lsu_wdata;
   assign io_wstrb  = lsu_wstrb;
   assign io_wlast  = 1'b1;
   assign ifu_rdata = io_rdata;
   assign ifu_rresp = io_rresp;
   assign ifu_rlast = io_rlast;
   assign lsu_rdata = io_rdata;
   assign lsu_rresp = io_rresp;
   assign lsu_rlast = io_rlast;
   assign lsu_bresp = io_bresp;

   // Handshake steering for the granted requester
   always_comb begin
      io_arvalid  = 1'b0;
      io_rready   = 1'b0;
      io_awvalid  = 1'b0;
      io_wvalid   = 1'b0;
      io_bready   = 1'b0;
      ifu_arready = 1'b0;
      ifu_rvalid  = 1'b0;
      lsu_arready = 1'b0;
      lsu_rvalid  = 1'b0;
      lsu_awready = 1'b0;
      lsu_wready  = 1'b0;
      lsu_bvalid  = 1'b0;
      case (state_q)
         RD_IFU: begin
            io_arvalid  = ifu_arvalid & ~addr_done_q;
            ifu_arready = io_arready & ~addr_done_q;
            ifu_rvalid  = io_rvalid;
            io_rready   = ifu_rready;
         end
         RD_LSU: begin
            io_arvalid  = lsu_arvalid & ~addr_done_q;
            lsu_arready = io_arready & ~addr_done_q;
            lsu_rvalid  = io_rvalid;
            io_rready   = lsu_rready;
         end
         WR_LSU: begin
            io_awvalid  = lsu_awvalid & ~addr_done_q;
            lsu_awready = io_awready & ~addr_done_q;
            io_wvalid   = lsu_wvalid & ~w_done_q;
            lsu_wready  = io_wready & ~w_done_q;
            lsu_bvalid  = io_bvalid;
            io_bready   = lsu_bready;
         end
         default: ;
      endcase
   end

   // Next-state: arbitration in IDLE, completion tracking in granted states
   always_comb begin
      state_d     = state_q;
      last_lsu_d  = last_lsu_q;
      addr_done_d = addr_done_q;
      w_done_d    = w_done_q;
      case (state_q)
         IDLE: begin
            addr_done_d = 1'b0;
            w_done_d    = 1'b0;
            // IFU wins when alone or when the LSU was granted last
            if (ifu_req && (!lsu_req || last_lsu_q)) begin
               state_d    = RD_IFU;
               last_lsu_d = 1'b0;
            end else if (lsu_req) begin
               state_d    = lsu_awvalid ? WR_LSU : RD_LSU;
               last_lsu_d = 1'b1;
            end
         end
         RD_IFU, RD_LSU: begin
            if (ar_hs)   addr_done_d = 1'b1;
            if (rd_done) state_d     = IDLE;
         end
         WR_LSU: begin
            if (aw_hs)   addr_done_d = 1'b1;
            if (w_hs)    w_done_d    = 1'b1;
            if (wr_done) state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         last_lsu_q  <= 1'b1;
         addr_done_q <= 1'b0;
         w_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_lsu_q  <= last_lsu_d;
         addr_done_q <= addr_done_d;
         w_done_q    <= w_done_d;
      end
   end

endmodule

// File: tb/tb_axi_arbiter.sv
// tb_axi_arbiter
//   Directed bench for axi_arbiter. The bench plays both requesters and the
//   downstream slave. Inputs change on the falling edge, and outputs are
//   checked 1 time unit later.
module tb_axi_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clock, reset;
   logic          ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready;
   logic [AW-1:0] ifu_araddr;
   logic [7:0]    ifu_arlen;
   logic [DW-1:0] ifu_rdata;
   logic [1:0]    ifu_rresp;
   logic          lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready;
   logic [AW-1:0] lsu_araddr;
   logic [7:0]    lsu_arlen;
   logic [DW-1:0] lsu_rdata;
   logic [1:0]    lsu_rresp;
   logic          lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
   logic [AW-1:0] lsu_awaddr;
   logic [DW-1:0] lsu_wdata;
   logic [3:0]    lsu_wstrb;
   logic [1:0]    lsu_bresp;
   logic          io_arvalid, io_arready, io_rvalid, io_rlast, io_rready;
   logic [AW-1:0] io_araddr;
   logic [7:0]    io_arlen;
   logic [DW-1:0] io_rdata;
   logic [1:0]    io_rresp;
   logic          io_awvalid, io_awready, io_wvalid, io_wlast, io_wready, io_bvalid, io_bready;
   logic [AW-1:0] io_awaddr;
   logic [7:0]    io_awlen;
   logic [DW-1:0] io_wdata;
   logic [3:0]    io_wstrb;
   logic [1:0]    io_bresp;

   int n_checks = 0;
   int n_fail   = 0;

   axi_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset(reset),
      .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
      .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
      .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rready(ifu_rready),
      .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen),
      .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
      .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rready(lsu_rready),
      .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
      .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
      .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp),
      .lsu_bready(lsu_bready),
      .io_arvalid(io_arvalid), .io_araddr(io_araddr), .io_arlen(io_arlen),
      .io_arready(io_arready), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
      .io_rresp(io_rresp), .io_rlast(io_rlast), .io_rready(io_rready),
      .io_awvalid(io_awvalid), .io_awaddr(io_awaddr), .io_awlen(io_awlen),
      .io_awready(io_awready), .io_wvalid(io_wvalid), .io_wdata(io_wdata),
      .io_wstrb(io_wstrb), .io_wlast(io_wlast), .io_wready(io_wready),
      .io_bvalid(io_bvalid), .io_bresp(io_bresp), .io_bready(io_bready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Every handshake output of the arbiter, packed; must be 0 when idle/in reset
   function automatic logic [11:0] all_hs();
      return {io_arvalid, io_awvalid, io_wvalid, io_rready, io_bready, ifu_arready,
              ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid};
   endfunction

   task automatic clear_inputs();
      ifu_arvalid = 0; ifu_araddr = '0; ifu_arlen = 0; ifu_rready = 0;
      lsu_arvalid = 0; lsu_araddr = '0; lsu_arlen = 0; lsu_rready = 0;
      lsu_awvalid = 0; lsu_awaddr = '0; lsu_wvalid = 0; lsu_wdata = '0;
      lsu_wstrb = 0; lsu_bready = 0;
      io_arready = 1; io_rvalid = 0; io_rdata = '0; io_rresp = 0; io_rlast = 0;
      io_awready = 0; io_wready = 0; io_bvalid = 0; io_bresp = 0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 0;
      clear_inputs();
      @(negedge clock);
      reset = 1;
   endtask

   // Serves one read grant, starting in the cycle the grant should first be
   // visible. Returns in the following IDLE cycle, or right after beat
   // 'abort_after' if that is positive.
   task automatic serve(input bit is_ifu, input logic [31:0] addr, input int beats,
                        input int stall, input logic [1:0] resp, input int abort_after);
      @(negedge clock); #1;
      chk("grant_arvalid", io_arvalid, 1);
      chk("grant_araddr", io_araddr, addr);
      chk("grant_arlen", io_arlen, beats - 1);
      chk("grant_arready", is_ifu ? ifu_arready : lsu_arready, 1);
      chk("other_arready", is_ifu ? lsu_arready : ifu_arready, 0);
      for (int b = 0; b < beats; b++) begin
         for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            if (is_ifu) ifu_arvalid = 0; else lsu_arvalid = 0;
            io_rvalid = 1; io_rdata = addr + b; io_rlast = (b == beats - 1); io_rresp = resp;
            ifu_rready = 0; lsu_rready = 0;
            #1;
            chk("stall_rvalid", is_ifu ? ifu_rvalid : lsu_rvalid, 1);
            chk("stall_rready", io_rready, 0);
         end
         @(negedge clock);
         if (is_ifu) ifu_arvalid = 0; else lsu_arvalid = 0;
         io_rvalid = 1; io_rdata = addr + b; io_rlast = (b == beats - 1); io_rresp = resp;
         ifu_rready = 1; lsu_rready = 1;
         #1;
         chk("beat_rvalid", is_ifu ? ifu_rvalid : lsu_rvalid, 1);
         chk("beat_rdata", is_ifu ? ifu_rdata : lsu_rdata, addr + b);
         chk("beat_rlast", is_ifu ? ifu_rlast : lsu_rlast, (b == beats - 1));
         chk("beat_rresp", is_ifu ? ifu_rresp : lsu_rresp, resp);
         chk("other_rvalid", is_ifu ? lsu_rvalid : ifu_rvalid, 0);
         chk("beat_rready", io_rready, 1);
         if (b + 1 == abort_after) begin
            $display("txn rd %s addr=0x%08h aborted after %0d beats", is_ifu ? "ifu" : "lsu", addr, b + 1);
            return;
         end
      end
      // IDLE: io_rvalid still high here and must not be forwarded
      @(negedge clock); #1;
      chk("idle_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
      chk("idle_hs", all_hs(), 0);
      io_rvalid = 0; io_rlast = 0;
      $display("txn rd %s addr=0x%08h beats=%0d resp=%0d", is_ifu ? "ifu" : "lsu", addr, beats, resp);
   endtask

   initial begin
      // Reset with stray activity on the inputs
      reset = 0;
      clear_inputs();
      ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_rready = 1;
      io_rvalid = 1; io_bvalid = 1; lsu_bready = 1;
      #1;
      chk("reset_outputs", all_hs(), 0);
      repeat (2) @(negedge clock);
      #1;
      chk("reset_hold", all_hs(), 0);

      // IFU single read right after reset release
      @(negedge clock);
      reset = 1; io_rvalid = 0; io_bvalid = 0;
      #1;
      chk("arb_latency", io_arvalid, 0);
      serve(1, 32'h8000_0000, 1, 0, 2'b00, -1);

      // IFU burst of 4 with a stall before every beat
      ifu_arvalid = 1; ifu_araddr = 32'h8000_1000; ifu_arlen = 3;
      #1;
      chk("burst_latency", io_arvalid, 0);
      serve(1, 32'h8000_1000, 4, 1, 2'b00, -1);

      // LSU single read with SLVERR
      lsu_arvalid = 1; lsu_araddr = 32'h0000_2000; lsu_arlen = 0;
      serve(0, 32'h0000_2000, 1, 0, 2'b10, -1);

      // LSU write and read together: write first, then read
      lsu_awvalid = 1; lsu_awaddr = 32'h0000_3000; lsu_wvalid = 1;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
      lsu_arvalid = 1; lsu_araddr = 32'h0000_4000; lsu_arlen = 0;
      @(negedge clock); #1;
      chk("wr_awvalid", io_awvalid, 1);
      chk("wr_awaddr", io_awaddr, 32'h0000_3000);
      chk("wr_awlen", io_awlen, 0);
      chk("wr_wvalid", io_wvalid, 1);
      chk("wr_wdata", io_wdata, 32'hDEAD_BEEF);
      chk("wr_wstrb", io_wstrb, 4'hF);
      chk("wr_wlast", io_wlast, 1);
      chk("wr_no_ar", io_arvalid, 0);
      io_wready = 1;
      #1;
      chk("wr_wready", lsu_wready, 1);
      chk("wr_awready_low", lsu_awready, 0);
      @(negedge clock);
      lsu_wvalid = 0; io_wready = 0; io_awready = 1;
      #1;
      chk("wr_awready", lsu_awready, 1);
      @(negedge clock);
      lsu_awvalid = 0; io_awready = 0;
      io_bvalid = 1; io_bresp = 2'b00; lsu_bready = 1;
      #1;
      chk("wr_bvalid", lsu_bvalid, 1);
      chk("wr_bready", io_bready, 1);
      chk("wr_bresp", lsu_bresp, 0);
      @(negedge clock); #1;
      chk("wr_idle_b", lsu_bvalid, 0);
      chk("wr_idle_hs", all_hs(), 0);
      io_bvalid = 0; lsu_bready = 0;
      $display("txn wr lsu addr=0x%08h data=0x%08h", 32'h0000_3000, 32'hDEAD_BEEF);
      serve(0, 32'h0000_4000, 1, 0, 2'b00, -1);

      // Reset in the middle of a burst, then a fresh LSU read
      ifu_arvalid = 1; ifu_araddr = 32'h8000_0100; ifu_arlen = 3;
      serve(1, 32'h8000_0100, 4, 0, 2'b00, 2);
      @(negedge clock);
      reset = 0;
      #1;
      chk("rst_async", all_hs(), 0);
      @(negedge clock);
      reset = 1; io_rvalid = 0; io_rlast = 0;
      lsu_arvalid = 1; lsu_araddr = 32'h0000_5000; lsu_arlen = 0;
      #1;
      chk("rst_idle", all_hs(), 0);
      serve(0, 32'h0000_5000, 1, 0, 2'b00, -1);

      // Conflict from reset: IFU, LSU, IFU, LSU
      do_reset();
      ifu_arvalid = 1; ifu_araddr = 32'h8000_0A00; ifu_arlen = 0;
      lsu_arvalid = 1; lsu_araddr = 32'h0000_0B00; lsu_arlen = 0;
      #1;
      chk("conf_latency", io_arvalid, 0);
      serve(1, 32'h8000_0A00, 1, 0, 2'b00, -1);
      ifu_arvalid = 1;
      serve(0, 32'h0000_0B00, 1, 0, 2'b00, -1);
      lsu_arvalid = 1;
      serve(1, 32'h8000_0A00, 1, 0, 2'b00, -1);
      serve(0, 32'h0000_0B00, 1, 0, 2'b00, -1);

      @(negedge clock); #1;
      chk("final_idle", all_hs(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
